// File: rtl/highlight_pkg.sv
// Shared types and default-derived widths for the highlight scheduler slice.
package highlight_pkg;

  localparam int unsigned DEF_ANGLE_RANGE    = 180;
  localparam int unsigned DEF_IMAGE_SIZE     = 388800;
  localparam int unsigned DEF_MAX_LINES      = 16;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 2048;

  localparam int unsigned ANGLE_W  = $clog2(DEF_ANGLE_RANGE);
  localparam int unsigned RADIUS_W = $clog2(DEF_IMAGE_SIZE);
  localparam int unsigned CNT_W    = $clog2(DEF_MAX_LINES + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    COLLECT   = 3'd1,
    ISSUE     = 3'd2,
    WAIT_ACK  = 3'd3,
    WAIT_DONE = 3'd4,
    DONE      = 3'd5
  } state_t;

endpackage

// File: rtl/line_fifo.sv
// Line-list buffer: DEPTH-entry FIFO with show-ahead read and wrap-bit full/empty.
module line_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 27
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW:0]      wr_q;
  logic [PW:0]      rd_q;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
  assign data_o  = mem_q[rd_q[PW-1:0]];

  // Pointer update; extra MSB distinguishes full from empty after wrap.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_i && !full_o) wr_q <= wr_q + 1'b1;
      if (pop_i && !empty_o) rd_q <= rd_q + 1'b1;
    end
  end

  // Storage write; contents are don't-care until pushed, so no reset.
  always_ff @(posedge clk_i) begin
    if (push_i && !full_o) mem_q[wr_q[PW-1:0]] <= data_i;
  end

endmodule

// File: rtl/highlight_scheduler.sv
// Collects line candidates per frame, then issues them one by one to a draw
// engine with a per-phase watchdog and per-frame status counters.
module highlight_scheduler
  import highlight_pkg::*;
#(
  parameter int unsigned ANGLE_RANGE    = DEF_ANGLE_RANGE,
  parameter int unsigned IMAGE_SIZE     = DEF_IMAGE_SIZE,
  parameter int unsigned MAX_LINES      = DEF_MAX_LINES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             frame_start,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [$clog2(ANGLE_RANGE)-1:0]   in_angle,
  input  logic [$clog2(IMAGE_SIZE)-1:0]    in_radius,
  input  logic                             in_last,
  output logic                             draw_start,
  output logic [$clog2(ANGLE_RANGE)-1:0]   draw_angle,
  output logic [$clog2(IMAGE_SIZE)-1:0]    draw_radius,
  input  logic                             draw_finish,
  output logic                             busy,
  output logic                             frame_done,
  output logic [$clog2(MAX_LINES+1)-1:0]   lines_drawn,
  output logic [$clog2(MAX_LINES+1)-1:0]   dropped,
  output logic                             timeout_err
);

  localparam int unsigned AW = $clog2(ANGLE_RANGE);
  localparam int unsigned RW = $clog2(IMAGE_SIZE);
  localparam int unsigned CW = $clog2(MAX_LINES + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned DW = AW + RW;

  localparam logic [AW:0]   ANGLE_LIM = (AW+1)'(ANGLE_RANGE);
  localparam logic [CW-1:0] CNT_MAX   = CW'(MAX_LINES);
  localparam logic [TW-1:0] TMR_LAST  = TW'(TIMEOUT_CYCLES - 1);

  state_t          state_q;
  logic [TW-1:0]   tmr_q;
  logic            draw_start_q;
  logic [AW-1:0]   draw_angle_q;
  logic [RW-1:0]   draw_radius_q;
  logic            busy_q;
  logic            frame_done_q;
  logic            timeout_q;
  logic [CW-1:0]   lines_q;
  logic [CW-1:0]   dropped_q;

  logic            fifo_full;
  logic            fifo_empty;
  logic            fifo_push;
  logic            fifo_pop;
  logic [DW-1:0]   fifo_dout;
  logic            accept;
  logic            angle_ok;
  logic            tmr_hit;

  assign in_ready  = (state_q == COLLECT) && !fifo_full;
  assign accept    = in_valid && in_ready;
  assign angle_ok  = ({1'b0, in_angle} < ANGLE_LIM);
  assign fifo_push = accept && angle_ok;
  assign fifo_pop  = (state_q == ISSUE) && !fifo_empty && draw_finish;
  assign tmr_hit   = (tmr_q == TMR_LAST);

  line_fifo #(
    .DEPTH (MAX_LINES),
    .WIDTH (DW)
  ) u_line_fifo (
    .clk_i   (clock),
    .rst_i   (reset),
    .push_i  (fifo_push),
    .data_i  ({in_angle, in_radius}),
    .pop_i   (fifo_pop),
    .data_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Frame sequencing, watchdog and status counters with registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      tmr_q         <= '0;
      draw_start_q  <= 1'b0;
      draw_angle_q  <= '0;
      draw_radius_q <= '0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      timeout_q     <= 1'b0;
      lines_q       <= '0;
      dropped_q     <= '0;
    end else begin
      draw_start_q <= 1'b0;
      frame_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (frame_start) begin
            state_q   <= COLLECT;
            busy_q    <= 1'b1;
            lines_q   <= '0;
            dropped_q <= '0;
            timeout_q <= 1'b0;
          end
        end
        COLLECT: begin
          if (accept) begin
            if (!angle_ok && dropped_q != CNT_MAX) dropped_q <= dropped_q + 1'b1;
            if (in_last) state_q <= ISSUE;
          end
        end
        ISSUE: begin
          tmr_q <= '0;
          if (fifo_empty) begin
            state_q      <= DONE;
            frame_done_q <= 1'b1;
          end else if (draw_finish) begin
            draw_angle_q  <= fifo_dout[DW-1:RW];
            draw_radius_q <= fifo_dout[RW-1:0];
            draw_start_q  <= 1'b1;
            state_q       <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (!draw_finish) begin
            state_q <= WAIT_DONE;
            tmr_q   <= '0;
          end else if (tmr_hit) begin
            timeout_q <= 1'b1;
            state_q   <= ISSUE;
          end else begin
            tmr_q <= tmr_q + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (draw_finish) begin
            if (lines_q != CNT_MAX) lines_q <= lines_q + 1'b1;
            state_q <= ISSUE;
          end else if (tmr_hit) begin
            timeout_q <= 1'b1;
            state_q   <= ISSUE;
          end else begin
            tmr_q <= tmr_q + 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign draw_start  = draw_start_q;
  assign draw_angle  = draw_angle_q;
  assign draw_radius = draw_radius_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign lines_drawn = lines_q;
  assign dropped     = dropped_q;
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_highlight_scheduler.sv
// Scoreboard bench: stimulus pushes expected draws/frame results, monitors pop
// and compare when the DUT presents draw_start or frame_done.
module tb_highlight_scheduler;
  import highlight_pkg::*;

  localparam int unsigned AR = 180;
  localparam int unsigned IS = 388800;
  localparam int unsigned ML = 16;
  localparam int unsigned TO = 2048;
  localparam int unsigned AW = ANGLE_W;
  localparam int unsigned RW = RADIUS_W;
  localparam int unsigned CW = CNT_W;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          frame_start = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [AW-1:0] in_angle = '0;
  logic [RW-1:0] in_radius = '0;
  logic          in_last = 1'b0;
  logic          draw_start;
  logic [AW-1:0] draw_angle;
  logic [RW-1:0] draw_radius;
  logic          draw_finish = 1'b1;
  logic          busy;
  logic          frame_done;
  logic [CW-1:0] lines_drawn;
  logic [CW-1:0] dropped;
  logic          timeout_err;

  highlight_scheduler #(
    .ANGLE_RANGE    (AR),
    .IMAGE_SIZE     (IS),
    .MAX_LINES      (ML),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .frame_start (frame_start),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_angle    (in_angle),
    .in_radius   (in_radius),
    .in_last     (in_last),
    .draw_start  (draw_start),
    .draw_angle  (draw_angle),
    .draw_radius (draw_radius),
    .draw_finish (draw_finish),
    .busy        (busy),
    .frame_done  (frame_done),
    .lines_drawn (lines_drawn),
    .dropped     (dropped),
    .timeout_err (timeout_err)
  );

  always #5 clock = ~clock;

  typedef struct { int unsigned angle; int unsigned radius; bit last; } ent_t;
  typedef struct { int unsigned angle; int unsigned radius; } draw_t;
  typedef struct { int unsigned lines; int unsigned drops; bit tout; } frame_t;

  draw_t  exp_draw[$];
  frame_t exp_frame[$];

  int vectors = 0;
  int miscompares = 0;

  int unsigned start_cnt = 0;
  int unsigned frame_cnt = 0;
  int unsigned frames_before = 0;
  int unsigned starts_before = 0;
  int unsigned exp_starts = 0;

  int unsigned eng_lat = 5;
  bit          force_low = 1'b0;
  int unsigned stuck_req = 0;
  int unsigned stuck_done = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  function automatic int unsigned sat(int unsigned v);
    return (v > ML) ? ML : v;
  endfunction

  // Scoreboard monitor for the command port and frame completion.
  always @(negedge clock) begin : monitor
    draw_t  d;
    frame_t f;
    if (!reset) begin
      if (draw_start) begin
        start_cnt++;
        check("draw_expected", exp_draw.size() > 0, 1);
        if (exp_draw.size() > 0) begin
          d = exp_draw.pop_front();
          check("draw_angle", draw_angle, d.angle);
          check("draw_radius", draw_radius, d.radius);
        end
      end
      if (frame_done) begin
        frame_cnt++;
        check("frame_expected", exp_frame.size() > 0, 1);
        if (exp_frame.size() > 0) begin
          f = exp_frame.pop_front();
          check("lines_drawn", lines_drawn, f.lines);
          check("dropped", dropped, f.drops);
          check("timeout_err", timeout_err, f.tout);
          check("draws_outstanding", exp_draw.size(), 0);
        end
      end
    end
  end

  // Draw-engine model: idle high, low for eng_lat cycles per command.
  always @(negedge clock) begin : engine
    bit          eng_busy;
    int unsigned eng_cnt;
    logic [AW-1:0] sv_a;
    logic [RW-1:0] sv_r;
    if (reset) begin
      eng_busy = 1'b0;
    end else if (eng_busy) begin
      if (eng_cnt <= 1) begin
        eng_busy = 1'b0;
        check("draw_angle_stable", draw_angle, sv_a);
        check("draw_radius_stable", draw_radius, sv_r);
      end else begin
        eng_cnt--;
      end
    end else if (draw_start) begin
      if (stuck_done < stuck_req) begin
        stuck_done++;
      end else begin
        eng_busy = 1'b1;
        eng_cnt  = eng_lat;
        sv_a     = draw_angle;
        sv_r     = draw_radius;
      end
    end
    draw_finish = !(eng_busy || force_low);
  end

  task automatic tick(input int unsigned n = 1);
    repeat (n) @(negedge clock);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_draw_start"}, draw_start, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_frame_done"}, frame_done, 0);
    check({tag, "_timeout_err"}, timeout_err, 0);
    check({tag, "_lines_drawn"}, lines_drawn, 0);
    check({tag, "_dropped"}, dropped, 0);
    check({tag, "_draw_angle"}, draw_angle, 0);
    check({tag, "_draw_radius"}, draw_radius, 0);
  endtask

  task automatic feed(input ent_t ents[$]);
    foreach (ents[i]) begin
      int unsigned w = 0;
      in_valid  = 1'b1;
      in_angle  = AW'(ents[i].angle);
      in_radius = RW'(ents[i].radius);
      in_last   = ents[i].last;
      while (!in_ready && w < 50) begin
        tick();
        w++;
      end
      if (w == 50) check("in_ready_wait", in_ready, 1);
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Reference model: entries up to the first in_last; legal angles are drawn
  // in order, the rest dropped; stuck commands are issued but never counted.
  task automatic run_frame(input ent_t ents[$], input int unsigned nstuck);
    int unsigned kept = 0;
    int unsigned drops = 0;
    frame_t f;
    foreach (ents[i]) begin
      if (ents[i].angle < AR) begin
        exp_draw.push_back('{angle: ents[i].angle, radius: ents[i].radius});
        kept++;
      end else begin
        drops++;
      end
      if (ents[i].last) break;
    end
    f.lines = sat(kept - nstuck);
    f.drops = sat(drops);
    f.tout  = (nstuck > 0);
    exp_frame.push_back(f);
    exp_starts    = kept;
    stuck_req     = stuck_req + nstuck;
    frames_before = frame_cnt;
    starts_before = start_cnt;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    feed(ents);
  endtask

  task automatic wait_frame(input int unsigned budget);
    int unsigned n = 0;
    while (frame_cnt == frames_before && n < budget) begin
      tick();
      n++;
    end
    tick();
    check("frame_done_count", frame_cnt - frames_before, 1);
    check("draw_start_count", start_cnt - starts_before, exp_starts);
    check("busy_after_frame", busy, 0);
  endtask

  task automatic wait_start(input int unsigned s0, input int unsigned budget);
    int unsigned n = 0;
    while (start_cnt == s0 && n < budget) begin
      tick();
      n++;
    end
    check("start_seen", start_cnt > s0, 1);
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    in_valid    = 1'b0;
    in_last     = 1'b0;
    frame_start = 1'b0;
    tick(3);
    exp_draw.delete();
    exp_frame.delete();
    stuck_req = stuck_done;
    reset = 1'b0;
    tick();
  endtask

  initial begin
    ent_t q[$];
    int unsigned s0;
    int unsigned f0;

    // Reset state.
    tick(2);
    check_all_zero("reset");
    reset = 1'b0;
    tick();

    // Three lines, 5-cycle engine.
    eng_lat = 5;
    q = '{'{10, 100, 0}, '{90, 200, 0}, '{179, 50, 1}};
    run_frame(q, 0);
    wait_frame(200);

    // Out-of-range angle with in_last: dropped, nothing drawn.
    q = '{'{180, 7, 1}};
    run_frame(q, 0);
    wait_frame(50);

    // Sixteen entries, last on the sixteenth: full buffer drained.
    q.delete();
    for (int i = 0; i < 16; i++)
      q.push_back('{$urandom_range(0, AR - 1), $urandom_range(0, IS - 1), i == 15});
    run_frame(q, 0);
    wait_frame(400);

    // Full buffer holds back the seventeenth entry.
    q.delete();
    for (int i = 0; i < 16; i++)
      q.push_back('{$urandom_range(0, AR - 1), $urandom_range(0, IS - 1), 0});
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    feed(q);
    in_valid  = 1'b1;
    in_angle  = AW'(5);
    in_radius = RW'(5);
    in_last   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("in_ready_full", in_ready, 0);
      tick();
    end
    check("busy_held", busy, 1);
    do_reset();

    // Dropped counter saturates.
    q.delete();
    for (int i = 0; i < 20; i++)
      q.push_back('{$urandom_range(AR, 255), $urandom_range(0, IS - 1), i == 19});
    run_frame(q, 0);
    wait_frame(100);

    // Engine busy at ISSUE: no command until draw_finish rises.
    force_low = 1'b1;
    q = '{'{1, 11, 0}, '{2, 22, 1}};
    run_frame(q, 0);
    s0 = start_cnt;
    tick(10);
    check("no_start_while_engine_busy", start_cnt - s0, 0);
    force_low = 1'b0;
    wait_frame(100);

    // Engine never acknowledges the first line: watchdog, then next line.
    q = '{'{33, 300, 0}, '{44, 400, 1}};
    run_frame(q, 1);
    wait_start(starts_before, 20);
    s0 = start_cnt;
    tick(TO - 8);
    check("timeout_not_early", timeout_err, 0);
    check("no_reissue_before_timeout", start_cnt - s0, 0);
    wait_frame(TO + 200);

    // Reset during WAIT_DONE abandons the frame.
    eng_lat = 30;
    q = '{'{60, 600, 0}, '{70, 700, 1}};
    run_frame(q, 0);
    wait_start(starts_before, 20);
    tick(5);
    f0 = frame_cnt;
    reset = 1'b1;
    tick();
    check_all_zero("midreset");
    do_reset();
    tick(5);
    check("no_frame_done_after_reset", frame_cnt - f0, 0);
    eng_lat = 5;
    q = '{'{10, 100, 0}, '{90, 200, 0}, '{179, 50, 1}};
    run_frame(q, 0);
    wait_frame(200);

    // Randomised frames.
    for (int fr = 0; fr < 25; fr++) begin
      int unsigned n = $urandom_range(1, 16);
      q.delete();
      for (int unsigned i = 0; i < n; i++)
        q.push_back('{$urandom_range(0, 255), $urandom_range(0, IS - 1), i == n - 1});
      eng_lat = $urandom_range(1, 6);
      run_frame(q, 0);
      wait_frame(600);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
